// File: rtl/power_up_mgr.sv
// Purpose: item slot manager that spawns power-ups on destroyed tiles, expires them and applies pickups to player stats.
// Latency: 1 cycle; spawns, pickups and expiries are visible on the registered outputs one cycle after the request.
// Backpressure: none; a spawn is dropped when every slot is busy or the tile already holds an item.
module power_up_mgr #(
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int TILE_PX       = 64,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 48,
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_SLOTS     = 3,
  parameter int MAX_LEVEL     = 3,
  parameter int ITEM_TIME     = 8,
  parameter int SPAWN_THRESH  = 255,
  parameter int BASE_SPEED    = 20,
  parameter int SPEED_STEP    = 8,
  localparam int ADDR_W       = $clog2(NUM_ROW*NUM_COL),
  localparam int LVL_W        = $clog2(MAX_LEVEL+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     game_over,
  input  logic                     we_in,
  input  logic [ADDR_W-1:0]        write_addr_in,
  input  logic [MAP_MEM_WIDTH-1:0] write_data_in,
  input  logic [10:0]              player_x [NUM_PLAYERS],
  input  logic [9:0]               player_y [NUM_PLAYERS],
  input  logic [31:0]              probability,
  output logic [ADDR_W-1:0]        item_addr [NUM_SLOTS],
  output logic [1:0]               item_type [NUM_SLOTS],
  output logic [NUM_SLOTS-1:0]     item_active,
  output logic [LVL_W-1:0]         speed_level [NUM_PLAYERS],
  output logic [LVL_W-1:0]         bomb_level [NUM_PLAYERS],
  output logic [LVL_W-1:0]         range_level [NUM_PLAYERS],
  output logic [7:0]               player_speed [NUM_PLAYERS],
  output logic [LVL_W:0]           max_bombs [NUM_PLAYERS],
  output logic [LVL_W:0]           bomb_range [NUM_PLAYERS],
  output logic [NUM_PLAYERS-1:0]   pickup_pulse
);

  localparam int CNT_W = $clog2(ITEM_TIME+1);

  // Per-slot lifetime counters (internal state only)
  logic [CNT_W-1:0]       life_cnt     [NUM_SLOTS];
  logic [CNT_W-1:0]       life_cnt_nxt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   active_nxt;
  logic [ADDR_W-1:0]      addr_nxt     [NUM_SLOTS];
  logic [1:0]             type_nxt     [NUM_SLOTS];

  // Player tile lookup
  logic [31:0]            pcol       [NUM_PLAYERS];
  logic [31:0]            prow       [NUM_PLAYERS];
  logic [ADDR_W-1:0]      ptile      [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] ptile_vld;

  // Pickup resolution
  logic [NUM_SLOTS-1:0]   taken;
  logic [NUM_PLAYERS-1:0] pick_vld;
  logic [1:0]             pick_type  [NUM_PLAYERS];
  logic [LVL_W-1:0]       spd_nxt    [NUM_PLAYERS];
  logic [LVL_W-1:0]       bmb_nxt    [NUM_PLAYERS];
  logic [LVL_W-1:0]       rng_nxt    [NUM_PLAYERS];

  // Spawn resolution
  logic                   spawn_req;
  logic                   spawn_dup;
  logic                   spawn_done;
  logic [1:0]             spawn_type;

  // Upper random bits carry no meaning for this block
  logic                   unused_prob;
  assign unused_prob = ^probability[31:10];

  // Map each player's sprite centre to a tile address; off-map centres never match a slot
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pcol[p]      = (32'(player_x[p]) + 32'(SPRITE_W/2)) / 32'(TILE_PX);
      prow[p]      = (32'(player_y[p]) + 32'(SPRITE_H/2)) / 32'(TILE_PX);
      ptile_vld[p] = (pcol[p] < 32'(NUM_COL)) && (prow[p] < 32'(NUM_ROW));
      ptile[p]     = ADDR_W'(prow[p] * 32'(NUM_COL) + pcol[p]);
    end
  end

  // Greedy pickup: lower players claim first, each player takes at most its lowest matching slot
  always_comb begin
    taken    = '0;
    pick_vld = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pick_type[p] = 2'd0;
      spd_nxt[p]   = speed_level[p];
      bmb_nxt[p]   = bomb_level[p];
      rng_nxt[p]   = range_level[p];
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (!game_over && ptile_vld[p] && item_active[s] && !taken[s] && !pick_vld[p] &&
            (item_addr[s] == ptile[p])) begin
          pick_vld[p]  = 1'b1;
          pick_type[p] = item_type[s];
          taken[s]     = 1'b1;
        end
      end
      if (pick_vld[p]) begin
        case (pick_type[p])
          2'd0: if (speed_level[p] < LVL_W'(MAX_LEVEL)) spd_nxt[p] = speed_level[p] + LVL_W'(1);
          2'd1: if (bomb_level[p]  < LVL_W'(MAX_LEVEL)) bmb_nxt[p] = bomb_level[p]  + LVL_W'(1);
          2'd2: if (range_level[p] < LVL_W'(MAX_LEVEL)) rng_nxt[p] = range_level[p] + LVL_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Slot update: pickup beats expiry; spawn only sees slots that were free at the start of the cycle
  always_comb begin
    active_nxt = item_active;
    spawn_dup  = 1'b0;
    spawn_done = 1'b0;
    spawn_req  = we_in && (write_data_in == '0) && !game_over &&
                 (32'(probability[7:0]) <= 32'(SPAWN_THRESH));
    spawn_type = (probability[9:8] == 2'd3) ? 2'd0 : probability[9:8];
    for (int s = 0; s < NUM_SLOTS; s++) begin
      addr_nxt[s]     = item_addr[s];
      type_nxt[s]     = item_type[s];
      life_cnt_nxt[s] = life_cnt[s];
      if (item_active[s] && (item_addr[s] == write_addr_in)) spawn_dup = 1'b1;
      if (!game_over && item_active[s]) begin
        if (taken[s]) begin
          active_nxt[s]   = 1'b0;
          life_cnt_nxt[s] = '0;
        end else if (tick) begin
          if (life_cnt[s] == CNT_W'(ITEM_TIME-1)) begin
            active_nxt[s]   = 1'b0;
            life_cnt_nxt[s] = '0;
          end else begin
            life_cnt_nxt[s] = life_cnt[s] + CNT_W'(1);
          end
        end
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (spawn_req && !spawn_dup && !spawn_done && !item_active[s]) begin
        spawn_done      = 1'b1;
        active_nxt[s]   = 1'b1;
        addr_nxt[s]     = write_addr_in;
        type_nxt[s]     = spawn_type;
        life_cnt_nxt[s] = '0;
      end
    end
  end

  // State and stat registers; stats are derived from the next levels so they track them with no lag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      item_active  <= '0;
      pickup_pulse <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        item_addr[s] <= '0;
        item_type[s] <= '0;
        life_cnt[s]  <= '0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        speed_level[p]  <= '0;
        bomb_level[p]   <= '0;
        range_level[p]  <= '0;
        player_speed[p] <= 8'(BASE_SPEED);
        max_bombs[p]    <= (LVL_W+1)'(1);
        bomb_range[p]   <= (LVL_W+1)'(1);
      end
    end else begin
      item_active  <= active_nxt;
      pickup_pulse <= pick_vld;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        item_addr[s] <= addr_nxt[s];
        item_type[s] <= type_nxt[s];
        life_cnt[s]  <= life_cnt_nxt[s];
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        speed_level[p]  <= spd_nxt[p];
        bomb_level[p]   <= bmb_nxt[p];
        range_level[p]  <= rng_nxt[p];
        player_speed[p] <= 8'(BASE_SPEED + SPEED_STEP * int'(spd_nxt[p]));
        max_bombs[p]    <= (LVL_W+1)'(bmb_nxt[p]) + (LVL_W+1)'(1);
        bomb_range[p]   <= (LVL_W+1)'(rng_nxt[p]) + (LVL_W+1)'(1);
      end
    end
  end

endmodule

// File: doc/power_up_mgr.md
POWER_UP_MGR -- requirements
Module: power_up_mgr

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_ROW 11, map rows.
- NUM_COL 19, map columns.
- TILE_PX 64, tile size in pixels.
- MAP_MEM_WIDTH 2, map write-data width.
- SPRITE_W 32, player sprite width in pixels.
- SPRITE_H 48, player sprite height in pixels.
- NUM_PLAYERS 2, player count (1..4).
- NUM_SLOTS 3, item slot count.
- MAX_LEVEL 3, per-stat level ceiling.
- ITEM_TIME 8, item lifetime in ticks.
- SPAWN_THRESH 255, spawn when probability[7:0] <= SPAWN_THRESH.
- BASE_SPEED 20, speed at level 0.
- SPEED_STEP 8, speed added per level.
- Derived: ADDR_W = $clog2(NUM_ROW*NUM_COL); LVL_W = $clog2(MAX_LEVEL+1).

REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous reset, active-low.
- tick, in, 1, one-cycle game-time strobe.
- game_over, in, 1, freeze.
- we_in, in, 1, map write strobe.
- write_addr_in, in, ADDR_W, tile written.
- write_data_in, in, MAP_MEM_WIDTH, 0 means block destroyed / free.
- player_x[NUM_PLAYERS], in, 11, player pixel x.
- player_y[NUM_PLAYERS], in, 10, player pixel y.
- probability, in, 32, random word.
- item_addr[NUM_SLOTS], out, ADDR_W, tile of each slot.
- item_type[NUM_SLOTS], out, 2, 0 speed, 1 bomb, 2 range.
- item_active, out, NUM_SLOTS, slot occupied.
- speed_level[NUM_PLAYERS], out, LVL_W.
- bomb_level[NUM_PLAYERS], out, LVL_W.
- range_level[NUM_PLAYERS], out, LVL_W.
- player_speed[NUM_PLAYERS], out, 8.
- max_bombs[NUM_PLAYERS], out, LVL_W+1.
- bomb_range[NUM_PLAYERS], out, LVL_W+1.
- pickup_pulse, out, NUM_PLAYERS, one-cycle pickup strobe per player.

Function
REQ-003 Spawn request: we_in=1, write_data_in=0, probability[7:0] <= SPAWN_THRESH, game_over=0.
REQ-004 Type: probability[9:8]; value 3 maps to 0 (speed).
REQ-005 Spawn target: lowest-index inactive slot, written at the same clock edge as the request. item_active, item_addr and item_type are visible the next cycle.
REQ-006 Dropped requests, no state change:
- all slots active;
- any active slot already holds write_addr_in.
REQ-007 Per-slot lifetime counter: cleared on spawn, increments on each tick while active and game_over=0. On reaching ITEM_TIME, the slot goes inactive at that edge.
REQ-008 Player tile: col = (x + SPRITE_W/2) / TILE_PX; row = (y + SPRITE_H/2) / TILE_PX; addr = row*NUM_COL + col. Computed combinationally.
REQ-009 Pickup: active slot addr equals a player's tile addr and game_over=0. At that edge:
- slot goes inactive;
- that player's level for item_type increments, saturating at MAX_LEVEL;
- pickup_pulse[p]=1 for exactly the next cycle.
- A pickup at MAX_LEVEL still consumes the item and still pulses.
REQ-010 Contention: when several players match one slot, the lowest player index wins. A player collects at most one item per cycle, the lowest-index matching slot; remaining items are collected on later cycles.
REQ-011 Priority in one cycle: pickup, then expiry, then spawn. A slot freed this cycle is not eligible for spawn this cycle. A spawn on a player's current tile is picked up no earlier than the following cycle.
REQ-012 Stat outputs are registered and updated in the same cycle as the level:
- player_speed = BASE_SPEED + SPEED_STEP*speed_level;
- max_bombs = 1 + bomb_level;
- bomb_range = 1 + range_level.
REQ-013 game_over=1 holds all slots, counters and levels frozen; spawns and pickups are ignored. Outputs keep their last values.
REQ-014 tick and we_in coincident on one cycle: both take effect independently.

Reset
REQ-015 rst=0 immediately clears all outputs and internal state, regardless of clk:
- item_active=0, item_addr=0, item_type=0, all levels 0, pickup_pulse=0, all counters 0;
- player_speed=BASE_SPEED, max_bombs=1, bomb_range=1.
REQ-016 Reset asserted mid-operation discards active items and levels. Operation resumes on the first clk edge after rst returns to 1.

Verification
REQ-017 Spawn: we_in=1, addr 20, data 0, probability=32'h0000_0100. Next cycle: item_active[0]=1, item_addr[0]=20, item_type[0]=1.
REQ-018 Pickup: player 0 at x=48, y=40 (tile 20) with a bomb item in slot 0. Next cycle: item_active[0]=0, bomb_level[0]=1, max_bombs[0]=2, pickup_pulse[0] high for 1 cycle.
REQ-019 Expiry: spawn with ITEM_TIME=8 and players away. After the 8th tick, item_active drops. At the 7th tick it is still active.
REQ-020 Full and duplicate:
- three spawns at 30, 31, 32 fill slots 0..2;
- a 4th spawn at 33 is dropped;
- a re-spawn at 31 leaves the slots unchanged.
REQ-021 Saturation: four speed pickups by player 1. speed_level[1] stays 3 and player_speed[1]=44; the 4th pickup still clears the slot and pulses.
REQ-022 Contention and freeze:
- both players on tile 20 with an item there: only player 0 gains a level;
- with game_over=1, a spawn and an overlapping player produce no change.
